// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch and data access.
// Data accesses win by default; a run counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_DM_RUN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // instruction fetch side
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  input  logic                  i_if_flush,
  output logic [DATA_W-1:0]     o_if_rdata,
  output logic                  o_if_ready,
  output logic                  o_if_stall,
  // data access side
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_W-1:0]     i_dm_addr,
  input  logic [DATA_W-1:0]     i_dm_wdata,
  input  logic [DATA_W/8-1:0]   i_dm_wstrb,
  output logic [DATA_W-1:0]     o_dm_rdata,
  output logic                  o_dm_ready,
  output logic                  o_dm_stall,
  // memory port
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  input  logic                  i_mem_ack
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RUN_W  = $clog2(MAX_DM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } state_t;

  state_t              r_state;
  logic [RUN_W-1:0]    r_dm_run;
  logic                r_drop;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;

  logic w_idle;
  logic w_if_valid;
  logic w_dm_grant;
  logic w_if_grant;
  logic w_if_ack;
  logic w_dm_ack;

  // Grant decision in IDLE: a flush suppresses the fetch grant for that cycle.
  assign w_idle     = (r_state == IDLE);
  assign w_if_valid = i_if_req && !i_if_flush;
  assign w_dm_grant = w_idle && i_dm_req && (!w_if_valid || (r_dm_run < RUN_MAX));
  assign w_if_grant = w_idle && !w_dm_grant && w_if_valid;
  assign w_if_ack   = (r_state == IF_ACC) && i_mem_ack;
  assign w_dm_ack   = (r_state == DM_ACC) && i_mem_ack;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_dm_run    <= '0;
      r_drop      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_dm_grant) begin
            r_state     <= DM_ACC;
            r_mem_we    <= i_dm_we;
            r_mem_addr  <= i_dm_addr;
            r_mem_wdata <= i_dm_wdata;
            r_mem_wstrb <= i_dm_we ? i_dm_wstrb : '0;
          end else if (w_if_grant) begin
            r_state     <= IF_ACC;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_if_addr;
            r_mem_wstrb <= '0;
          end
        end
        IF_ACC: begin
          // The transaction always completes; a flush only hides its result.
          if (i_mem_ack) begin
            r_state     <= IDLE;
            r_drop      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
          end else if (i_if_flush) begin
            r_drop <= 1'b1;
          end
        end
        DM_ACC: begin
          if (i_mem_ack) begin
            r_state     <= IDLE;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Count data grants that bypass a waiting fetch.
      if (!i_if_req || w_if_grant) begin
        r_dm_run <= '0;
      end else if (w_dm_grant && (r_dm_run != RUN_MAX)) begin
        r_dm_run <= r_dm_run + RUN_W'(1);
      end
    end
  end

  assign o_mem_req   = !w_idle;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

  assign o_if_rdata  = i_mem_rdata;
  assign o_dm_rdata  = i_mem_rdata;
  assign o_if_ready  = w_if_ack && !r_drop && !i_if_flush;
  assign o_dm_ready  = w_dm_ack;
  assign o_if_stall  = i_if_req && !o_if_ready;
  assign o_dm_stall  = i_dm_req && !o_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions are queued
// as requests are driven and checked against each acknowledged transfer.
module tb_mem_port_arbiter;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_ready, o_if_stall, o_dm_ready, o_dm_stall, o_mem_req, o_mem_we;
  logic [3:0]  o_mem_wstrb;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_RUN(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready), .o_if_stall(o_if_stall),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_wstrb(dm_wstrb), .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready),
    .o_dm_stall(o_dm_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        if_rdy;
    logic        dm_rdy;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   ack_dly = 2;
  logic inject_ack = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h00A0_0093;
      32'h0000_3000: return 32'h1234_5678;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic void exp_if(input logic [31:0] a, input logic rdy);
    txn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0; t.wstrb = '0;
    t.if_rdy = rdy; t.dm_rdy = 1'b0; t.rdata = rdata_for(a);
    exp_q.push_back(t);
  endfunction

  function automatic void exp_dm(input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.wstrb = we ? ws : 4'h0;
    t.if_rdy = 1'b0; t.dm_rdy = 1'b1; t.rdata = rdata_for(a);
    exp_q.push_back(t);
  endfunction

  // Memory model: acks ack_dly cycles after mem_req rises; inject_ack forces a stray ack.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (mem_ack) begin
        mem_ack = 1'b0; cnt = 0;
      end else if (inject_ack) begin
        mem_ack = 1'b1; inject_ack = 1'b0; mem_rdata = 32'hBAD0_0BAD;
      end else if (o_mem_req) begin
        cnt++;
        if (cnt >= ack_dly) begin
          mem_ack = 1'b1; mem_rdata = rdata_for(o_mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: compare every acknowledged transfer; readies only with an ack.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst_n && o_mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          t = exp_q.pop_front();
          check("sb_addr",   64'(o_mem_addr),  64'(t.addr));
          check("sb_we",     64'(o_mem_we),    64'(t.we));
          check("sb_wstrb",  64'(o_mem_wstrb), 64'(t.wstrb));
          if (t.we) check("sb_wdata", 64'(o_mem_wdata), 64'(t.wdata));
          check("sb_if_rdy", 64'(o_if_ready),  64'(t.if_rdy));
          check("sb_dm_rdy", 64'(o_dm_ready),  64'(t.dm_rdy));
          if (t.if_rdy) check("sb_if_rdata", 64'(o_if_rdata), 64'(t.rdata));
          if (t.dm_rdy) check("sb_dm_rdata", 64'(o_dm_rdata), 64'(t.rdata));
        end
      end else begin
        check("no_ready", 64'({o_if_ready, o_dm_ready}), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_if_done();
    int n = 0;
    do begin
      @(negedge clk); n++;
      check("if_stall", 64'(o_if_stall), 64'(if_req && !o_if_ready));
    end while (!o_if_ready && n < LIMIT);
    check("if_done", 64'(o_if_ready), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    wait_if_done();
  endtask

  task automatic do_dm(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_wstrb = ws;
    do begin
      @(negedge clk); n++;
      check("dm_stall", 64'(o_dm_stall), 64'(dm_req && !o_dm_ready));
    end while (!o_dm_ready && n < LIMIT);
    check("dm_done", 64'(o_dm_ready), 64'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(o_mem_req),   64'd0);
    check("rst_mem_we",  64'(o_mem_we),    64'd0);
    check("rst_addr",    64'(o_mem_addr),  64'd0);
    check("rst_wdata",   64'(o_mem_wdata), 64'd0);
    check("rst_wstrb",   64'(o_mem_wstrb), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 1: lone fetch, ack two cycles after mem_req
    ack_dly = 2;
    exp_if(32'h100, 1'b1);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check("t1_req_lat", 64'(o_mem_req), 64'd0);
    wait_if_done();
    idle(2);

    // 2: simultaneous store and fetch, store first
    ack_dly = 1;
    exp_dm(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
    exp_if(32'h104, 1'b1);
    fork
      do_dm(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
      do_fetch(32'h104);
    join
    idle(2);

    // 3: continuous data requests against a pending fetch
    for (int i = 0; i < 4; i++) exp_dm(1'b1, 32'h2100 + 32'(4 * i), 32'h1000 + 32'(i), 4'h3);
    exp_if(32'h400, 1'b1);
    for (int i = 4; i < 6; i++) exp_dm(1'b1, 32'h2100 + 32'(4 * i), 32'h1000 + 32'(i), 4'h3);
    fork
      do_fetch(32'h400);
      begin
        for (int i = 0; i < 6; i++) do_dm(1'b1, 32'h2100 + 32'(4 * i), 32'h1000 + 32'(i), 4'h3);
      end
    join
    idle(2);

    // 4: flush while fetch outstanding, redirected fetch follows
    ack_dly = 3;
    exp_if(32'h180, 1'b0);
    exp_if(32'h200, 1'b1);
    if_req = 1'b1; if_addr = 32'h180;
    @(posedge clk); #1;
    if_flush = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    check("t4_req", 64'(o_mem_req), 64'd1);
    check("t4_rdy", 64'(o_if_ready), 64'd0);
    @(posedge clk); #1;
    if_flush = 1'b0;
    wait_if_done();
    idle(2);

    // 5: reset during a data access, stray ack afterwards
    ack_dly = 100;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2400; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_req", 64'(o_mem_req), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; inject_ack = 1'b1;
    @(negedge clk);
    check("t5_req_after", 64'(o_mem_req),  64'd0);
    check("t5_dm_rdy",    64'(o_dm_ready), 64'd0);
    check("t5_we_after",  64'(o_mem_we),   64'd0);
    ack_dly = 2;
    idle(1);
    exp_if(32'h500, 1'b1);
    do_fetch(32'h500);
    idle(2);

    // 6: load with fetch waiting; one idle cycle between grants
    exp_dm(1'b0, 32'h3000, 32'h0, 4'h0);
    exp_if(32'h600, 1'b1);
    fork
      begin
        do_dm(1'b0, 32'h3000, 32'h0, 4'h0);
        @(negedge clk);
        check("t6_bubble", 64'(o_mem_req), 64'd0);
      end
      do_fetch(32'h600);
    join
    idle(2);

    // Mixed random traffic, one request at a time
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      logic [31:0] wd;
      int kind;
      a = $urandom() & 32'hFFFF_FFFC;
      wd = $urandom();
      kind = $urandom_range(0, 2);
      ack_dly = $urandom_range(1, 4);
      if (kind == 0) begin
        exp_if(a, 1'b1);
        do_fetch(a);
      end else if (kind == 1) begin
        exp_dm(1'b1, a, wd, 4'(i + 1));
        do_dm(1'b1, a, wd, 4'(i + 1));
      end else begin
        exp_dm(1'b0, a, 32'h0, 4'h0);
        do_dm(1'b0, a, 32'h0, 4'h0);
      end
      idle(1);
    end

    idle(3);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
